clint: RTL and testbench
========================

# clint

Core-local interrupt controller that sits on the data bus as a responder to the core's `dbus_req_t` accesses. It holds the RISC-V `msip`, `mtimecmp` and `mtime` registers. It drives the core's `swint` and `trint` inputs. It accepts one request at a time in the memory-stage address window `BASE`..`BASE+0xFFFF` and answers with a single-cycle `addr_ok`/`data_ok` pulse. Requests outside the window get no response and are left to the bus decoder.

## Interface
- `BASE`, default 64'h0000_0000_0200_0000: window base; a hit is `dreq.addr[63:16] == BASE[63:16]`.
- `TICK_DIV`, default 1: `mtime` increments once every `TICK_DIV` clk cycles; legal range 1..65535.

- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: reset, synchronous, active-high.
- `dreq` input, `dbus_req_t`: uses `valid`, `addr` [63:0], `strobe` [7:0], `data` [63:0]; a write is any nonzero strobe.
- `dresp` output, `dbus_resp_t`: drives `addr_ok`, `data_ok`, `data` [63:0].
- `swint` output, 1 bit: software interrupt, equal to `msip[0]`.
- `trint` output, 1 bit: timer interrupt, registered `mtime >= mtimecmp`.

## Operation
- Register map, by offset `addr[15:0]` with `addr[2:0]` ignored:
  - 0x0000 `msip`: only bit 0 is writable, via lane 0; read returns zero-extended bit 0.
  - 0x4000 `mtimecmp`: 64-bit.
  - 0xBFF8 `mtime`: 64-bit.
  - Any other offset reads 0; writes to it are dropped but still acknowledged.
- Writes merge per byte lane: lane i, `data[8i+7:8i]`, is written only if `strobe[i]`.
- Two-state FSM, IDLE and RESP:
  - IDLE: if `dreq.valid` and hit, latch offset, strobe and data, perform the write at this edge, load the read value into `resp_data`, then go to RESP. Otherwise stay in IDLE.
  - RESP: `addr_ok = data_ok = 1`, `dresp.data = resp_data`. Always return to IDLE.
- Requester protocol: hold `dreq` stable until `data_ok`. In the cycle after `data_ok`, `valid` may already carry the next request, which IDLE accepts.
- Prescaler `pcnt` (16 bit) counts 0..`TICK_DIV`-1 and wraps to 0. A tick occurs in the cycle where `pcnt == TICK_DIV-1`. With `TICK_DIV`=1, every cycle is a tick.
- On a tick, `mtime <= mtime + 1`, wrapping modulo 2^64 (all-ones goes to 0).
- A write to `mtime` in the same cycle as a tick wins: the merged write value is stored and the increment is lost. `pcnt` continues counting regardless.
- `trint <= (mtime >= mtimecmp)` every cycle, using an unsigned 64-bit compare of current register values.
- `swint` is combinational from the `msip` flop.

## Timing
- Reset values:
  - FSM in IDLE.
  - `dresp` all zero.
  - `msip` = 0, `swint` = 0.
  - `mtime` = 0, `pcnt` = 0.
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF.
  - `trint` = 0.
- Reset mid-transaction: the FSM returns to IDLE, no `data_ok` is issued, and register writes that commit on the reset edge are discarded.
- Access latency: request accepted at edge N (end of the cycle with `valid`) gives `data_ok` high for exactly the cycle after N. Back-to-back requests complete at most every 2 cycles.
- Read data is the register value before edge N. A `mtime` read therefore excludes any increment at N.
- Write effect appears in registers in the cycle after N, which is the same cycle as `data_ok`.
- Interrupt timing:
  - `trint` lags the register state by 1 cycle. It rises 1 cycle after the first cycle where `mtime >= mtimecmp`.
  - `trint` falls 1 cycle after a `mtimecmp`/`mtime` write makes the compare false.
  - `swint` changes in the cycle after the accepting edge.
- Outside the window: `dresp` stays all zero and no state changes.

## Test plan
- **Reset and free-running count:** reset, then `TICK_DIV`=4 and 40 idle cycles → `mtime`=10. Read 0xBFF8 returns the value at accept; `data_ok` is high 1 cycle after accept; `trint`=0 and `swint`=0 throughout.
- **Timer compare:** write `mtimecmp`=20 with strobe 0xFF, `TICK_DIV`=1 → `trint` rises the cycle after `mtime` reaches 20. Then write `mtimecmp`=all-ones → `trint` drops 1 cycle after `data_ok`.
- **Software interrupt and partial writes:**
  - Write `msip` with data 1, strobe 0x01 → `swint`=1; write data 0 → `swint`=0.
  - Write `mtimecmp` data 0xAABB..., strobe 0x0F → only the low 32 bits change; readback confirms.
- **Write-vs-tick collision:** `TICK_DIV`=1, write `mtime`=64'hFFFF_FFFF_FFFF_FFFE on a tick cycle → next cycle `mtime` = ..FE, then ..FF, then 0 (wrap).
- **Undecoded and outside addresses:**
  - Read offset 0x1000 → `data_ok` with data 0, no state change.
  - Request at `BASE`+0x10000 → no `addr_ok`/`data_ok` for 10 cycles.
- **Reset mid-transaction:** assert `reset` in the accept cycle of a `mtime` write → no `data_ok`, `mtime`=0 after reset, and the FSM accepts a fresh request 1 cycle after `reset` deasserts.

Source files
------------

// File: rtl/clint.sv
// Core-local interrupt controller: msip / mtimecmp / mtime behind a single-outstanding
// data-bus responder, driving the core's software and timer interrupt lines.
package clint_pkg;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

endpackage

module clint
  import clint_pkg::*;
#(
  parameter logic [63:0] BASE     = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       swint,
  output logic       trint
);

  // Register offsets as 8-byte word indices (addr[15:3]).
  localparam logic [12:0] OFF_MSIP     = 13'h0000;
  localparam logic [12:0] OFF_MTIMECMP = 13'h0800;
  localparam logic [12:0] OFF_MTIME    = 13'h17FF;
  localparam logic [15:0] TICK_LAST    = 16'(TICK_DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  function automatic logic [63:0] merge_lanes(input logic [63:0] old_val,
                                              input logic [63:0] wdata,
                                              input logic [7:0]  strobe);
    logic [63:0] res;
    res = old_val;
    for (int i = 0; i < 8; i++) begin
      if (strobe[i]) begin
        res[8*i +: 8] = wdata[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_val[8*i +: 8];
      end
    end
    return res;
  endfunction

  state_t      state_q, state_d;
  logic        msip_q, msip_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [63:0] mtime_q, mtime_d;
  logic [15:0] pcnt_q, pcnt_d;
  logic        trint_q, trint_d;
  logic [63:0] resp_data_q, resp_data_d;

  logic        hit_s;
  logic        accept_s;
  logic        write_s;
  logic        tick_s;
  logic [12:0] offset_s;
  logic [63:0] rd_data_s;
  logic        unused_addr_s;

  assign hit_s         = dreq.valid && (dreq.addr[63:16] == BASE[63:16]);
  assign accept_s      = hit_s && (state_q == IDLE);
  assign write_s       = accept_s && (dreq.strobe != 8'h00);
  assign offset_s      = dreq.addr[15:3];
  assign tick_s        = (pcnt_q == TICK_LAST);
  assign unused_addr_s = ^dreq.addr[2:0];

  // Next-state logic of the request handshake.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = RESP;
        end else begin
          state_d = IDLE;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read mux; unmapped offsets read as zero.
  always_comb begin
    rd_data_s = 64'h0;
    case (offset_s)
      OFF_MSIP:     rd_data_s = {63'h0, msip_q};
      OFF_MTIMECMP: rd_data_s = mtimecmp_q;
      OFF_MTIME:    rd_data_s = mtime_q;
      default:      rd_data_s = 64'h0;
    endcase
  end

  // Register updates; a bus write to mtime overrides the same-cycle tick.
  always_comb begin
    msip_d      = msip_q;
    mtimecmp_d  = mtimecmp_q;
    mtime_d     = mtime_q;
    pcnt_d      = pcnt_q;
    resp_data_d = 64'h0;

    if (tick_s) begin
      pcnt_d = 16'h0000;
    end else begin
      pcnt_d = pcnt_q + 16'h0001;
    end

    if (accept_s) begin
      resp_data_d = rd_data_s;
    end else begin
      resp_data_d = 64'h0;
    end

    if (write_s && (offset_s == OFF_MSIP) && dreq.strobe[0]) begin
      msip_d = dreq.data[0];
    end else begin
      msip_d = msip_q;
    end

    if (write_s && (offset_s == OFF_MTIMECMP)) begin
      mtimecmp_d = merge_lanes(mtimecmp_q, dreq.data, dreq.strobe);
    end else begin
      mtimecmp_d = mtimecmp_q;
    end

    if (write_s && (offset_s == OFF_MTIME)) begin
      mtime_d = merge_lanes(mtime_q, dreq.data, dreq.strobe);
    end else if (tick_s) begin
      mtime_d = mtime_q + 64'h1;
    end else begin
      mtime_d = mtime_q;
    end
  end

  assign trint_d = (mtime_q >= mtimecmp_q);

  // State and register flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      msip_q      <= 1'b0;
      mtimecmp_q  <= 64'hFFFF_FFFF_FFFF_FFFF;
      mtime_q     <= 64'h0;
      pcnt_q      <= 16'h0000;
      trint_q     <= 1'b0;
      resp_data_q <= 64'h0;
    end else begin
      state_q     <= state_d;
      msip_q      <= msip_d;
      mtimecmp_q  <= mtimecmp_d;
      mtime_q     <= mtime_d;
      pcnt_q      <= pcnt_d;
      trint_q     <= trint_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Response pulse is taken straight from the RESP state flop.
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = (state_q == RESP);
    dresp.data_ok = (state_q == RESP);
    dresp.data    = resp_data_q;
  end

  assign swint = msip_q;
  assign trint = trint_q;

endmodule

// File: tb/tb_clint.sv
// Directed bench for clint: two instances (TICK_DIV 4 and 1) and a queue of expected responses.
module tb_clint;
  import clint_pkg::*;

  localparam logic [63:0] BASE = 64'h0000_0000_0200_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct {
    logic        chk;
    logic [63:0] data;
  } exp_t;

  logic       clk;
  logic       reset4, reset1;
  dbus_req_t  req4, req1;
  dbus_resp_t resp4, resp1;
  logic       swint4, trint4, swint1, trint1;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  clint #(.BASE(BASE), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset4), .dreq(req4), .dresp(resp4), .swint(swint4), .trint(trint4)
  );

  clint #(.BASE(BASE), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset1), .dreq(req1), .dresp(resp1), .swint(swint1), .trint(trint1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic dbus_resp_t resp_of(input bit sel);
    return sel ? resp1 : resp4;
  endfunction

  task automatic drive_req(input bit sel, input logic [63:0] addr, input logic [7:0] strb,
                           input logic [63:0] data);
    dbus_req_t r;
    r.valid  = 1'b1;
    r.addr   = addr;
    r.strobe = strb;
    r.data   = data;
    if (sel) req1 = r;
    else     req4 = r;
  endtask

  task automatic drop_req(input bit sel);
    if (sel) req1 = '0;
    else     req4 = '0;
  endtask

  task automatic start_req(input bit sel, input logic [63:0] addr, input logic [7:0] strb,
                           input logic [63:0] data, input logic chk, input logic [63:0] expv);
    exp_t e;
    e.chk  = chk;
    e.data = expv;
    exp_q.push_back(e);
    drive_req(sel, addr, strb, data);
  endtask

  task automatic finish_req(input bit sel, input string tag);
    dbus_resp_t r;
    exp_t       e;
    int         n;
    n = 0;
    r = resp_of(sel);
    while (!r.data_ok && n < 8) begin
      @(negedge clk);
      n++;
      r = resp_of(sel);
    end
    check({tag, " data_ok"}, 64'(r.data_ok), 64'h1);
    check({tag, " addr_ok"}, 64'(r.addr_ok), 64'h1);
    e = exp_q.pop_front();
    if (e.chk) check({tag, " rdata"}, r.data, e.data);
    drop_req(sel);
    @(negedge clk);
    r = resp_of(sel);
    check({tag, " ok pulse ends"}, {62'h0, r.addr_ok, r.data_ok}, 64'h0);
  endtask

  task automatic do_req(input bit sel, input logic [63:0] addr, input logic [7:0] strb,
                        input logic [63:0] data, input logic chk, input logic [63:0] expv,
                        input string tag);
    dbus_resp_t r;
    start_req(sel, addr, strb, data, chk, expv);
    @(negedge clk);
    r = resp_of(sel);
    check({tag, " latency"}, 64'(r.data_ok), 64'h1);
    finish_req(sel, tag);
  endtask

  initial begin
    req4   = '0;
    req1   = '0;
    reset4 = 1'b1;
    reset1 = 1'b1;
    @(negedge clk);
    @(negedge clk);

    check("rst resp4 ok", {62'h0, resp4.addr_ok, resp4.data_ok}, 64'h0);
    check("rst resp4 data", resp4.data, 64'h0);
    check("rst swint4", 64'(swint4), 64'h0);
    check("rst trint4", 64'(trint4), 64'h0);
    check("rst resp1 data", resp1.data, 64'h0);
    check("rst swint1", 64'(swint1), 64'h0);

    // Free-running count with TICK_DIV=4: ticks at edges 4,8,..,40.
    reset4 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i % 10 == 0) begin
        check("idle swint4", 64'(swint4), 64'h0);
        check("idle trint4", 64'(trint4), 64'h0);
      end
    end
    do_req(1'b0, BASE + 64'hBFF8, 8'h00, 64'h0, 1'b1, 64'd10, "mtime read4 a");
    repeat (2) @(negedge clk);
    do_req(1'b0, BASE + 64'hBFF8, 8'h00, 64'h0, 1'b1, 64'd11, "mtime read4 b");
    check("trint4 stays low", 64'(trint4), 64'h0);

    // Timer compare with TICK_DIV=1: mtime equals the edge count since reset.
    reset1 = 1'b0;
    do_req(1'b1, BASE + 64'h4000, 8'hFF, 64'd20, 1'b1, ONES, "cmp write");
    for (int k = 3; k <= 25; k++) begin
      @(negedge clk);
      check($sformatf("trint rise k=%0d", k), 64'(trint1), 64'(k >= 21));
    end
    do_req(1'b1, BASE + 64'h4000, 8'hFF, ONES, 1'b1, 64'd20, "cmp clear");
    check("trint fall", 64'(trint1), 64'h0);

    // Software interrupt and lane-masked writes.
    do_req(1'b1, BASE, 8'h01, 64'h1, 1'b1, 64'h0, "msip set");
    check("swint set", 64'(swint1), 64'h1);
    do_req(1'b1, BASE + 64'h4, 8'h00, 64'h0, 1'b1, 64'h1, "msip read");
    do_req(1'b1, BASE, 8'h01, 64'h0, 1'b1, 64'h1, "msip clr");
    check("swint clr", 64'(swint1), 64'h0);
    do_req(1'b1, BASE, 8'hFE, ONES, 1'b1, 64'h0, "msip lane0 off");
    check("swint unmasked lane", 64'(swint1), 64'h0);
    do_req(1'b1, BASE + 64'h4000, 8'h0F, 64'hAABB_CCDD_1122_3344, 1'b1, ONES, "cmp partial");
    do_req(1'b1, BASE + 64'h4000, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_1122_3344, "cmp readback");

    // Undecoded offsets inside the window.
    do_req(1'b1, BASE + 64'h1000, 8'h00, 64'h0, 1'b1, 64'h0, "undec read");
    do_req(1'b1, BASE + 64'h2000, 8'hFF, ONES, 1'b1, 64'h0, "undec write");
    do_req(1'b1, BASE + 64'h4000, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_1122_3344, "cmp after undec");
    do_req(1'b1, BASE, 8'h00, 64'h0, 1'b1, 64'h0, "msip after undec");

    // Outside the window: no handshake and no write.
    drive_req(1'b1, BASE + 64'h1_4000, 8'hFF, 64'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("outside no ok", {62'h0, resp1.addr_ok, resp1.data_ok}, 64'h0);
    end
    drop_req(1'b1);
    @(negedge clk);
    do_req(1'b1, BASE + 64'h4000, 8'h00, 64'h0, 1'b1, 64'hFFFF_FFFF_1122_3344, "cmp after outside");

    // Write-vs-tick collision and 64-bit wrap.
    start_req(1'b1, BASE + 64'hBFF8, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 64'h0);
    @(negedge clk);
    check("coll data_ok", 64'(resp1.data_ok), 64'h1);
    check("coll mtime FE", u_dut1.mtime_q, 64'hFFFF_FFFF_FFFF_FFFE);
    finish_req(1'b1, "coll");
    check("coll mtime FF", u_dut1.mtime_q, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clk);
    check("coll mtime wrap", u_dut1.mtime_q, 64'h0);
    do_req(1'b1, BASE + 64'hBFF8, 8'h00, 64'h0, 1'b1, 64'h0, "wrap read");

    // Reset in the accept cycle of an mtime write.
    drive_req(1'b0, BASE + 64'hBFF8, 8'hFF, 64'h1234);
    reset4 = 1'b1;
    @(negedge clk);
    check("rst mid no ok", {62'h0, resp4.addr_ok, resp4.data_ok}, 64'h0);
    reset4 = 1'b0;
    drop_req(1'b0);
    do_req(1'b0, BASE + 64'hBFF8, 8'h00, 64'h0, 1'b1, 64'h0, "post-rst mtime");
    do_req(1'b0, BASE + 64'h4000, 8'h00, 64'h0, 1'b1, ONES, "post-rst cmp");
    check("post-rst trint4", 64'(trint4), 64'h0);
    check("post-rst swint4", 64'(swint4), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
